// File: rtl/sram_rr_ctrl.sv
// Round-robin front end for a single-port SRAM: two requesters share one command slot
// per cycle, with an optional zero-fill sweep after reset and tagged read-data return.
module sram_rr_ctrl #(
    parameter int DATA_BIT   = 8,
    parameter int ADDR_BIT   = 8,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic                a_we,
    input  logic [ADDR_BIT-1:0] a_addr,
    input  logic [DATA_BIT-1:0] a_wdata,
    output logic                a_rvalid,
    output logic [DATA_BIT-1:0] a_rdata,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic                b_we,
    input  logic [ADDR_BIT-1:0] b_addr,
    input  logic [DATA_BIT-1:0] b_wdata,
    output logic                b_rvalid,
    output logic [DATA_BIT-1:0] b_rdata,
    output logic                sram_ena,
    output logic                sram_rw_ena,
    output logic [ADDR_BIT-1:0] sram_addr,
    output logic [DATA_BIT-1:0] sram_wdata,
    input  logic [DATA_BIT-1:0] sram_rdata,
    output logic                init_done
);

    // Handshake: a request transfers in any cycle where x_valid && x_ready; ready is
    // combinational, never asserted for both ports at once, and read responses
    // cannot be stalled.
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_BIT:0] CNT_ONE = {{ADDR_BIT{1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [ADDR_BIT:0]   clr_cnt;
    logic                ptr_b;
    logic                a_gnt, b_gnt;
    logic                cmd_ena, cmd_rd;
    logic [ADDR_BIT-1:0] cmd_addr;
    logic [DATA_BIT-1:0] cmd_wdata;
    logic                t1_vld, t1_port, t2_vld, t2_port;

    always_comb begin
        state_nxt = state;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        cmd_ena   = 1'b0;
        cmd_rd    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        case (state)
            ST_INIT: begin
                // The extra counter bit marks the sweep as finished one cycle after the last write.
                if (!clr_cnt[ADDR_BIT]) begin
                    cmd_ena  = 1'b1;
                    cmd_addr = clr_cnt[ADDR_BIT-1:0];
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (init_done) begin
                    a_gnt = a_valid & (~ptr_b | ~b_valid);
                    b_gnt = b_valid & ~a_gnt;
                end
                if (a_gnt) begin
                    cmd_ena   = 1'b1;
                    cmd_rd    = ~a_we;
                    cmd_addr  = a_addr;
                    cmd_wdata = a_wdata;
                end else if (b_gnt) begin
                    cmd_ena   = 1'b1;
                    cmd_rd    = ~b_we;
                    cmd_addr  = b_addr;
                    cmd_wdata = b_wdata;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign a_ready = a_gnt;
    assign b_ready = b_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            clr_cnt     <= '0;
            ptr_b       <= 1'b0;
            init_done   <= 1'b0;
            sram_ena    <= 1'b0;
            sram_rw_ena <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
            t1_vld      <= 1'b0;
            t1_port     <= 1'b0;
            t2_vld      <= 1'b0;
            t2_port     <= 1'b0;
            a_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rvalid    <= 1'b0;
            b_rdata     <= '0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == ST_RUN);
            if (state == ST_INIT && !clr_cnt[ADDR_BIT])
                clr_cnt <= clr_cnt + CNT_ONE;
            if (a_gnt)
                ptr_b <= 1'b1;
            else if (b_gnt)
                ptr_b <= 1'b0;
            sram_ena    <= cmd_ena;
            sram_rw_ena <= cmd_rd;
            sram_addr   <= cmd_addr;
            sram_wdata  <= cmd_wdata;
            // Read tags ride alongside the command so the response returns to its issuer.
            t1_vld   <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
            t1_port  <= b_gnt;
            t2_vld   <= t1_vld;
            t2_port  <= t1_port;
            a_rvalid <= t2_vld & ~t2_port;
            b_rvalid <= t2_vld & t2_port;
            if (t2_vld && !t2_port)
                a_rdata <= sram_rdata;
            if (t2_vld && t2_port)
                b_rdata <= sram_rdata;
        end
    end

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Directed bench for sram_rr_ctrl with a behavioural registered-read SRAM attached.
module tb_sram_rr_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, a_ready, a_we, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_valid, b_ready, b_we, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          sram_ena, sram_rw_ena, init_done;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_rdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] mem [16] = '{default: 8'hFF};
    logic [DW-1:0] vals [4] = '{8'h33, 8'h44, 8'h55, 8'h66};

    always #5 clk = ~clk;

    sram_rr_ctrl #(.DATA_BIT(DW), .ADDR_BIT(AW), .INIT_CLEAR(1)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .sram_ena(sram_ena), .sram_rw_ena(sram_rw_ena), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .init_done(init_done)
    );

    // SRAM model: write on enable with rw_ena=0, registered read data otherwise.
    always @(posedge clk) begin
        if (rst)
            sram_rdata <= '0;
        else if (sram_ena) begin
            if (sram_rw_ena)
                sram_rdata <= mem[sram_addr];
            else
                mem[sram_addr] <= sram_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_a(1'b1, 1'b0, 4'd0, 8'h00);
        drive_b(1'b1, 1'b0, 4'd0, 8'h00);
        repeat (3) step();
        @(negedge clk);
        n_total++;
        if ({sram_ena, sram_rw_ena, sram_addr, sram_wdata, init_done, a_ready, b_ready, a_rvalid, b_rvalid, a_rdata, b_rdata} !== '0)
            $display("FAIL reset_outputs: got ena=%b rw=%b addr=%h wd=%h done=%b ar=%b br=%b arv=%b brv=%b, expected all zero",
                     sram_ena, sram_rw_ena, sram_addr, sram_wdata, init_done, a_ready, b_ready, a_rvalid, b_rvalid);
        else n_pass++;
        step();
        rst = 1'b0;
    endtask

    task automatic test_init_sweep();
        for (int k = 0; k < 16; k++) begin
            step();
            @(negedge clk);
            n_total++;
            if ({sram_ena, sram_rw_ena, sram_addr, sram_wdata, a_ready, b_ready, init_done} !== {1'b1, 1'b0, 4'(k), 8'h00, 3'b000})
                $display("FAIL init_sweep_%0d: got ena=%b rw=%b addr=%0d wd=%h ar=%b br=%b done=%b, expected 1 0 %0d 00 0 0 0",
                         k, sram_ena, sram_rw_ena, sram_addr, sram_wdata, a_ready, b_ready, init_done, k);
            else n_pass++;
        end
        step();
        @(negedge clk);
        n_total++;
        if ({init_done, sram_ena, a_ready, b_ready} !== 4'b1010)
            $display("FAIL init_done: got done=%b ena=%b ar=%b br=%b, expected 1 0 1 0", init_done, sram_ena, a_ready, b_ready);
        else n_pass++;
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        step();
    endtask

    task automatic test_write_then_read();
        drive_a(1'b1, 1'b1, 4'd5, 8'hA5);
        @(negedge clk);
        n_total++;
        if ({a_ready, b_ready} !== 2'b10)
            $display("FAIL wr_grant: got ar=%b br=%b, expected 1 0", a_ready, b_ready);
        else n_pass++;
        step();
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        drive_b(1'b1, 1'b0, 4'd5, 8'h00);
        @(negedge clk);
        n_total++;
        if ({b_ready, sram_ena, sram_rw_ena, sram_addr, sram_wdata} !== {1'b1, 1'b1, 1'b0, 4'd5, 8'hA5})
            $display("FAIL wr_cmd: got br=%b ena=%b rw=%b addr=%h wd=%h, expected 1 1 0 5 a5",
                     b_ready, sram_ena, sram_rw_ena, sram_addr, sram_wdata);
        else n_pass++;
        step();
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        @(negedge clk);
        n_total++;
        if ({sram_ena, sram_rw_ena, sram_addr, a_rvalid, b_rvalid} !== {1'b1, 1'b1, 4'd5, 2'b00})
            $display("FAIL rd_cmd: got ena=%b rw=%b addr=%h arv=%b brv=%b, expected 1 1 5 0 0",
                     sram_ena, sram_rw_ena, sram_addr, a_rvalid, b_rvalid);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({sram_ena, sram_rw_ena, sram_addr, sram_wdata, a_rvalid, b_rvalid} !== '0)
            $display("FAIL idle_cmd: got ena=%b rw=%b addr=%h wd=%h arv=%b brv=%b, expected all zero",
                     sram_ena, sram_rw_ena, sram_addr, sram_wdata, a_rvalid, b_rvalid);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, 8'hA5})
            $display("FAIL raw_resp: got arv=%b brv=%b brd=%h, expected 0 1 a5", a_rvalid, b_rvalid, b_rdata);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if ({a_rvalid, b_rvalid, b_rdata} !== {2'b00, 8'hA5})
            $display("FAIL rdata_hold: got arv=%b brv=%b brd=%h, expected 0 0 a5", a_rvalid, b_rvalid, b_rdata);
        else n_pass++;
        step();
    endtask

    task automatic test_alternate();
        drive_a(1'b1, 1'b1, 4'd1, 8'h11);
        step();
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        drive_b(1'b1, 1'b1, 4'd2, 8'h22);
        step();
        for (int t = 0; t < 10; t++) begin
            if (t < 6) begin
                drive_a(1'b1, 1'b0, 4'd1, 8'h00);
                drive_b(1'b1, 1'b0, 4'd2, 8'h00);
            end else begin
                drive_a(1'b0, 1'b0, 4'd0, 8'h00);
                drive_b(1'b0, 1'b0, 4'd0, 8'h00);
            end
            @(negedge clk);
            n_total++;
            if ({a_ready, b_ready, a_rvalid, b_rvalid} !==
                {t < 6 && t % 2 == 0, t < 6 && t % 2 == 1, t >= 3 && t <= 7 && t % 2 == 1, t >= 4 && t <= 8 && t % 2 == 0})
                $display("FAIL alt_%0d: got ar=%b br=%b arv=%b brv=%b", t, a_ready, b_ready, a_rvalid, b_rvalid);
            else n_pass++;
            if (t == 3 || t == 8) begin
                n_total++;
                if ({a_rdata, b_rdata} !== {8'h11, (t == 8) ? 8'h22 : 8'hA5})
                    $display("FAIL alt_data_%0d: got ard=%h brd=%h, expected 11 %h", t, a_rdata, b_rdata, (t == 8) ? 8'h22 : 8'hA5);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_only_b();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b1, 4'(3 + i), vals[i]);
            step();
        end
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        for (int t = 0; t < 8; t++) begin
            if (t < 4) drive_b(1'b1, 1'b0, 4'(3 + t), 8'h00);
            else       drive_b(1'b0, 1'b0, 4'd0, 8'h00);
            @(negedge clk);
            n_total++;
            if ({a_ready, b_ready, a_rvalid, b_rvalid} !== {1'b0, t < 4, 1'b0, t >= 3 && t <= 6})
                $display("FAIL onlyb_%0d: got ar=%b br=%b arv=%b brv=%b", t, a_ready, b_ready, a_rvalid, b_rvalid);
            else n_pass++;
            if (t >= 3 && t <= 6) begin
                n_total++;
                if (b_rdata !== vals[t - 3])
                    $display("FAIL onlyb_data_%0d: got %h expected %h", t, b_rdata, vals[t - 3]);
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_reset_flush();
        drive_b(1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        n_total++;
        if (b_ready !== 1'b1)
            $display("FAIL flush_grant: got br=%b expected 1", b_ready);
        else n_pass++;
        step();
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        rst = 1'b1;
        step();
        @(negedge clk);
        n_total++;
        if ({init_done, b_rvalid, sram_ena} !== 3'b000)
            $display("FAIL flush_t2: got done=%b brv=%b ena=%b, expected 0 0 0", init_done, b_rvalid, sram_ena);
        else n_pass++;
        step();
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({init_done, b_rvalid, a_rvalid} !== 3'b000)
            $display("FAIL flush_t3: got done=%b brv=%b arv=%b, expected 0 0 0", init_done, b_rvalid, a_rvalid);
        else n_pass++;
        repeat (16) step();
        @(negedge clk);
        n_total++;
        if ({init_done, sram_ena, sram_addr} !== {1'b0, 1'b1, 4'd15})
            $display("FAIL reinit_last: got done=%b ena=%b addr=%0d, expected 0 1 15", init_done, sram_ena, sram_addr);
        else n_pass++;
        step();
        @(negedge clk);
        n_total++;
        if (init_done !== 1'b1)
            $display("FAIL reinit_done: got %b expected 1", init_done);
        else n_pass++;
        step();
    endtask

    task automatic test_clear_read();
        for (int t = 0; t < 8; t++) begin
            case (t)
                0:       drive_a(1'b1, 1'b0, 4'd1, 8'h00);
                1:       drive_a(1'b1, 1'b1, 4'd7, 8'h77);
                2:       drive_a(1'b1, 1'b0, 4'd7, 8'h00);
                3:       drive_a(1'b1, 1'b0, 4'd9, 8'h00);
                default: drive_a(1'b0, 1'b0, 4'd0, 8'h00);
            endcase
            @(negedge clk);
            n_total++;
            if ({a_ready, a_rvalid, b_rvalid} !== {t < 4, t == 3 || t == 5 || t == 6, 1'b0})
                $display("FAIL clr_%0d: got ar=%b arv=%b brv=%b", t, a_ready, a_rvalid, b_rvalid);
            else n_pass++;
            if (t == 3 || t == 5 || t == 6) begin
                n_total++;
                if (a_rdata !== ((t == 5) ? 8'h77 : 8'h00))
                    $display("FAIL clr_data_%0d: got %h expected %h", t, a_rdata, (t == 5) ? 8'h77 : 8'h00);
                else n_pass++;
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 4'd0, 8'h00);
        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
        test_reset();
        test_init_sweep();
        test_write_then_read();
        test_alternate();
        test_only_b();
        test_reset_flush();
        test_clear_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
